// File: rtl/mem_rw_scheduler_pkg.sv
// Shared request type and scheduler state encoding for the arbiter-to-EMIF path.
package ctrl_signal_types;

  localparam int ADDR_W = 27;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
  } mem_request_t;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_HOLD    = 2'd1,
    S_PRESENT = 2'd2
  } rw_sched_state_t;

  function automatic logic req_valid(input mem_request_t req);
    return req.read | req.write;
  endfunction

endpackage

// File: rtl/mem_rw_scheduler_credit.sv
// Read credit tracking: reads accepted but not yet answered, plus a sticky underflow flag.
module rd_credit_counter #(
  parameter int MAX_OUTSTANDING = 8,
  localparam int PW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic rd_accept,
  input  logic rd_resp_valid,
  output logic credit_avail,
  output logic err_underflow
);

  localparam logic [PW-1:0] CAP = PW'(MAX_OUTSTANDING);

  logic [PW-1:0] rd_pending_r;
  logic [PW-1:0] rd_pending_nx_s;
  logic          err_underflow_r;

  // Next pending count: simultaneous accept and response cancel out.
  always_comb begin
    rd_pending_nx_s = rd_pending_r;
    if (rd_accept && !rd_resp_valid) begin
      if (rd_pending_r < CAP) begin
        rd_pending_nx_s = rd_pending_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_pending_nx_s = rd_pending_r;
      end
    end else if (!rd_accept && rd_resp_valid && (rd_pending_r != {PW{1'b0}})) begin
      rd_pending_nx_s = rd_pending_r - {{(PW-1){1'b0}}, 1'b1};
    end else begin
      rd_pending_nx_s = rd_pending_r;
    end
  end

  // Pending-count and sticky underflow registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending_r    <= {PW{1'b0}};
      err_underflow_r <= 1'b0;
    end else begin
      rd_pending_r    <= rd_pending_nx_s;
      err_underflow_r <= err_underflow_r | (rd_resp_valid && (rd_pending_r == {PW{1'b0}}));
    end
  end

  assign credit_avail  = (rd_pending_r < CAP);
  assign err_underflow = err_underflow_r;

endmodule

// File: rtl/mem_rw_scheduler.sv
// Single-entry issue stage with read/write turnaround gap and read credit cap.
// Optional performance counters are enabled with `define RW_SCHED_PERF_CNT_EN.
module mem_rw_scheduler
  import ctrl_signal_types::*;
#(
  parameter int MAX_OUTSTANDING = 8,
  parameter int TURNAROUND      = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  mem_request_t in_request,
  output logic         in_ready,
  output mem_request_t out_request,
  input  logic         out_port_ready,
  input  logic         rd_resp_valid,
  output logic         err_underflow
`ifdef RW_SCHED_PERF_CNT_EN
  ,
  output logic [31:0]  perf_ta_stall_cnt,
  output logic [31:0]  perf_credit_stall_cnt
`endif
);

  localparam logic [3:0] TA = 4'(TURNAROUND);

  rw_sched_state_t state_r, state_nx_s;
  mem_request_t    stage_r, stage_nx_s;
  mem_request_t    out_req_r, out_req_nx_s;
  logic            last_dir_r;
  logic [3:0]      gap_r, gap_nx_s;
  logic            credit_avail_s;
  logic            issue_s, accept_s, in_ready_s;
  logic            eff_dir_s, gap_met_s, direct_s;

  // Handshake decode; in_ready never looks at in_request so the arbiter sees no loop.
  always_comb begin
    issue_s    = (state_r == S_PRESENT) && out_port_ready;
    in_ready_s = ((state_r == S_EMPTY) || issue_s) && credit_avail_s;
    accept_s   = req_valid(in_request) && in_ready_s;
    if (issue_s) begin
      eff_dir_s = stage_r.write;
      gap_nx_s  = 4'd0;
    end else if (gap_r >= TA) begin
      eff_dir_s = last_dir_r;
      gap_nx_s  = TA;
    end else begin
      eff_dir_s = last_dir_r;
      gap_nx_s  = gap_r + 4'd1;
    end
    // Gap is judged on its post-edge value so an opposite-direction issue sees exactly TA idle cycles.
    gap_met_s = (gap_nx_s >= TA);
    direct_s  = (in_request.write == eff_dir_s) || gap_met_s;
  end

  // Next-state, stage and output selection.
  always_comb begin
    state_nx_s = state_r;
    stage_nx_s = accept_s ? in_request : stage_r;
    case (state_r)
      S_EMPTY: begin
        if (accept_s) begin
          state_nx_s = direct_s ? S_PRESENT : S_HOLD;
        end else begin
          state_nx_s = S_EMPTY;
        end
      end
      S_HOLD: begin
        if (gap_met_s) begin
          state_nx_s = S_PRESENT;
        end else begin
          state_nx_s = S_HOLD;
        end
      end
      S_PRESENT: begin
        if (issue_s && accept_s) begin
          state_nx_s = direct_s ? S_PRESENT : S_HOLD;
        end else if (issue_s) begin
          state_nx_s = S_EMPTY;
        end else begin
          state_nx_s = S_PRESENT;
        end
      end
      default: state_nx_s = S_EMPTY;
    endcase
    out_req_nx_s = stage_nx_s;
    if (state_nx_s != S_PRESENT) begin
      out_req_nx_s.read  = 1'b0;
      out_req_nx_s.write = 1'b0;
    end else begin
      out_req_nx_s.read  = stage_nx_s.read;
      out_req_nx_s.write = stage_nx_s.write;
    end
  end

  // Stage, direction history, gap counter and registered output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= S_EMPTY;
      stage_r    <= '0;
      out_req_r  <= '0;
      last_dir_r <= 1'b0;
      gap_r      <= TA;
    end else begin
      state_r    <= state_nx_s;
      stage_r    <= stage_nx_s;
      out_req_r  <= out_req_nx_s;
      last_dir_r <= issue_s ? stage_r.write : last_dir_r;
      gap_r      <= gap_nx_s;
    end
  end

  rd_credit_counter #(
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) u_credit (
    .clk          (clk),
    .reset_n      (reset_n),
    .rd_accept    (accept_s && in_request.read),
    .rd_resp_valid(rd_resp_valid),
    .credit_avail (credit_avail_s),
    .err_underflow(err_underflow)
  );

  assign in_ready    = in_ready_s;
  assign out_request = out_req_r;

`ifdef RW_SCHED_PERF_CNT_EN
  logic [31:0] perf_ta_r, perf_credit_r;

  // Turnaround and credit stall cycle counters, free-running modulo 2^32.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_ta_r     <= 32'd0;
      perf_credit_r <= 32'd0;
    end else begin
      perf_ta_r     <= perf_ta_r + ((state_r == S_HOLD) ? 32'd1 : 32'd0);
      perf_credit_r <= perf_credit_r +
                       ((req_valid(in_request) && !credit_avail_s) ? 32'd1 : 32'd0);
    end
  end

  assign perf_ta_stall_cnt     = perf_ta_r;
  assign perf_credit_stall_cnt = perf_credit_r;
`endif

endmodule

// File: tb/tb_mem_rw_scheduler.sv
// Scoreboard bench for mem_rw_scheduler (MAX_OUTSTANDING=4, TURNAROUND=2).
module tb_mem_rw_scheduler;
  import ctrl_signal_types::*;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [26:0] addr;
    int          cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n;
  mem_request_t in_request;
  logic         in_ready;
  mem_request_t out_request;
  logic         out_port_ready;
  logic         rd_resp_valid;
  logic         err_underflow;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  mem_rw_scheduler #(
    .MAX_OUTSTANDING(4),
    .TURNAROUND     (2)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_request    (in_request),
    .in_ready      (in_ready),
    .out_request   (out_request),
    .out_port_ready(out_port_ready),
    .rd_resp_valid (rd_resp_valid),
    .err_underflow (err_underflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every issue (valid output taken by the port) pops one expected entry.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n && (out_request.read || out_request.write) && out_port_ready) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_issue: got rd=%0b wr=%0b addr=%h at cycle %0d, required no issue",
                 out_request.read, out_request.write, out_request.address, cyc);
      end else begin
        e = sb_q.pop_front();
        if (out_request.read !== e.rd || out_request.write !== e.wr ||
            out_request.address !== e.addr || cyc != e.cyc) begin
          n_err++;
          $display("FAIL issue_check: got rd=%0b wr=%0b addr=%h cycle %0d, required rd=%0b wr=%0b addr=%h cycle %0d",
                   out_request.read, out_request.write, out_request.address, cyc,
                   e.rd, e.wr, e.addr, e.cyc);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request until accepted; expected issue cycle = accept cycle + lat.
  task automatic issue_req(input logic rd, input logic wr, input logic [26:0] addr, input int lat);
    bit done = 1'b0;
    exp_t e;
    in_request = {rd, wr, addr};
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        e.rd = rd; e.wr = wr; e.addr = addr; e.cyc = cyc + lat;
        sb_q.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_request = '0;
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: got no accept of addr %h in 20 cycles, required accept", addr);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    in_request     = '0;
    out_port_ready = 1'b1;
    rd_resp_valid  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_request", 32'(out_request), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_err_underflow", 32'(err_underflow), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Reads back-to-back, one per cycle.
    issue_req(1'b1, 1'b0, 27'h8, 1);
    issue_req(1'b1, 1'b0, 27'h8, 1);
    issue_req(1'b1, 1'b0, 27'h8, 1);
    // Write accepted on the same edge the last read issues: two bubbles.
    issue_req(1'b0, 1'b1, 27'hA, 3);
    repeat (5) step();
    // Read after an idle gap following the write: no bubble; fourth read fills credits.
    issue_req(1'b1, 1'b0, 27'h14, 1);
    @(negedge clk);
    chk("credit_full_present", 32'(in_ready), 32'd0);
    step();
    rd_resp_valid = 1'b1;
    @(negedge clk);
    chk("credit_full_empty", 32'(in_ready), 32'd0);
    step();
    rd_resp_valid = 1'b0;
    @(negedge clk);
    chk("credit_reopen", 32'(in_ready), 32'd1);
    step();

    // Write with the port stalled for 3 cycles.
    out_port_ready = 1'b0;
    issue_req(1'b0, 1'b1, 27'hA4, 4);
    repeat (3) begin
      @(negedge clk);
      chk("stall_out_stable", 32'(out_request), 32'({1'b0, 1'b1, 27'hA4}));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_port_ready = 1'b1;
    step();
    // Read accepted the cycle after a write issue: two bubbles.
    issue_req(1'b1, 1'b0, 27'h20, 2);
    repeat (2) step();
    @(negedge clk);
    chk("credit_full_again", 32'(in_ready), 32'd0);
    step();

    // Drain all credits, then one extra response underflows.
    rd_resp_valid = 1'b1;
    repeat (4) step();
    rd_resp_valid = 1'b0;
    @(negedge clk);
    chk("drained_in_ready", 32'(in_ready), 32'd1);
    chk("no_underflow_yet", 32'(err_underflow), 32'd0);
    step();
    rd_resp_valid = 1'b1;
    step();
    rd_resp_valid = 1'b0;
    @(negedge clk);
    chk("underflow_set", 32'(err_underflow), 32'd1);
    repeat (3) step();
    @(negedge clk);
    chk("underflow_sticky", 32'(err_underflow), 32'd1);
    step();

    // Stall a write, then reset mid-stall.
    out_port_ready = 1'b0;
    in_request = {1'b0, 1'b1, 27'h30};
    @(negedge clk);
    chk("stall_accept_ready", 32'(in_ready), 32'd1);
    step();
    in_request = '0;
    @(negedge clk);
    chk("stalled_write_shown", 32'(out_request), 32'({1'b0, 1'b1, 27'h30}));
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset_out_request", 32'(out_request), 32'd0);
    chk("midreset_in_ready", 32'(in_ready), 32'd1);
    chk("midreset_err_underflow", 32'(err_underflow), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
    out_port_ready = 1'b1;
    issue_req(1'b1, 1'b0, 27'h44, 1);
    repeat (3) step();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
